// File: rtl/vs_indirect_buffer_if.sv
// Wishbone classic port of the value-storage indirect buffer.
// The slave side is the buffer; the master side is the bus/DMA.
interface vs_indirect_buffer_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [1:0]  wb_adr_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_cyc_i,
        output wb_stb_i,
        output wb_we_i,
        output wb_adr_i,
        output wb_dat_i,
        input  wb_dat_o,
        input  wb_ack_o,
        input  wb_err_o
    );

    modport slave (
        input  wb_cyc_i,
        input  wb_stb_i,
        input  wb_we_i,
        input  wb_adr_i,
        input  wb_dat_i,
        output wb_dat_o,
        output wb_ack_o,
        output wb_err_o
    );
endinterface

// File: rtl/vs_indirect_buffer.sv
// Circular sample buffer read back through one indirect Wishbone register.
// Define VS_OVERWRITE_EN to let a full buffer overwrite its oldest entry.
module vs_indirect_buffer #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter logic [15:0] EOD_WORD   = 16'hffff
) (
    input  logic                clk,
    input  logic                reset,
    vs_indirect_buffer_if.slave wb,
    input  logic                sample_valid,
    input  logic [15:0]         sample_data
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    localparam cnt_t FULL = cnt_t'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [15:0] dat_q, dat_d;
    logic        we_q, we_d;
    logic [1:0]  adr_q, adr_d;
    logic [15:0] wdat_q, wdat_d;
    logic        buf_q, buf_d;
    logic        pause_q, pause_d;
    logic        ovf_q, ovf_d;
    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    cnt_t        count_q, count_d;
    cnt_t        rd_left_q, rd_left_d;

    logic [15:0] mem [DEPTH];
    logic [15:0] rdata_q;

    logic        req;
    logic        buf_rd;
    logic        rd_en;
    logic        in_resp;
    logic        do_pause;
    logic        do_resume;
    logic        do_clr;
    logic        full;
    logic        block;
    logic        cap;
    logic        drop;
    logic [15:0] status;

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign wb.wb_dat_o = dat_q;

    assign req    = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~err_q;
    assign buf_rd = ~wb.wb_we_i & (wb.wb_adr_i == 2'd0)
                  & pause_q & (rd_left_q != '0);
    assign rd_en  = (state_q == S_IDLE) & req & buf_rd;

    // Register side effects land on the response edge, so a reset
    // that aborts a transaction also cancels its effect.
    assign in_resp   = (state_q == S_RESP);
    assign do_pause  = in_resp & we_q & (adr_q == 2'd0)
                     & (wdat_q == 16'h0);
    assign do_resume = in_resp & we_q & (adr_q == 2'd0)
                     & (wdat_q != 16'h0);
    assign do_clr    = in_resp & we_q & (adr_q == 2'd1);

    assign full = (count_q == FULL);
`ifdef VS_OVERWRITE_EN
    assign block = 1'b0;
`else
    assign block = full;
`endif
    assign cap  = sample_valid & ~pause_q & ~do_pause & ~block;
    assign drop = sample_valid & ~cap;

    assign status = {pause_q, ovf_q, 14'(count_q)};

    always_comb begin
        pause_d   = pause_q;
        ovf_d     = (do_clr ? 1'b0 : ovf_q) | drop;
        wr_ptr_d  = wr_ptr_q + ptr_t'(cap);
        rd_ptr_d  = rd_ptr_q;
        rd_left_d = rd_left_q;
        count_d   = count_q + cnt_t'(cap & ~full);
        if (do_pause) begin
            pause_d   = 1'b1;
            rd_ptr_d  = wr_ptr_q - ptr_t'(count_q);
            rd_left_d = count_q;
        end
        if (do_resume) begin
            pause_d = 1'b0;
`ifndef VS_OVERWRITE_EN
            count_d = cnt_t'(cap);
`endif
        end
        if (in_resp & buf_q) begin
            rd_ptr_d  = rd_ptr_q + ptr_t'(1);
            rd_left_d = rd_left_q - cnt_t'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = dat_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        buf_d   = buf_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = wb.wb_we_i;
                    adr_d   = wb.wb_adr_i;
                    wdat_d  = wb.wb_dat_i;
                    buf_d   = buf_rd;
                    state_d = buf_rd ? S_RD_WAIT : S_RESP;
                end
            end
            S_RD_WAIT: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
                buf_d   = 1'b0;
                dat_d   = 16'h0;
                if (adr_q[1]) begin
                    err_d = 1'b1;
                end else begin
                    ack_d = 1'b1;
                    if (!we_q) begin
                        if (adr_q[0]) dat_d = status;
                        else          dat_d = buf_q ? rdata_q : EOD_WORD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= 16'h0;
            we_q      <= 1'b0;
            adr_q     <= 2'd0;
            wdat_q    <= 16'h0;
            buf_q     <= 1'b0;
            pause_q   <= 1'b0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_left_q <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            dat_q     <= dat_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            buf_q     <= buf_d;
            pause_q   <= pause_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_left_q <= rd_left_d;
        end
    end

    // Storage is never reset; only the pointers and count are.
    always_ff @(posedge clk) begin
        if (cap) mem[wr_ptr_q] <= sample_data;
        if (rd_en) rdata_q <= mem[rd_ptr_q];
    end
endmodule
